// File: rtl/tx_symbol_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_symbol_queue_pkg
// Description : Shared types and constants for the transmit symbol queue.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_symbol_queue_pkg;

  // Width of one encoded switch symbol.
  localparam int SYM_W = 3;

  // Default watchdog limit: 4 s at the 100 MHz board clock.
  localparam int TIMEOUT_CYCLES_DEF = 400_000_000;

  // Controller state encodings.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    WAIT_HI = ST_WAIT_HI,
    WAIT_LO = ST_WAIT_LO
  } state_e;

endpackage : tx_symbol_queue_pkg
`default_nettype wire

// File: rtl/tx_symbol_queue_sym_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tx_symbol_queue_sym_fifo
// Description : Symbol FIFO with occupancy count, sticky overflow flag and a
//               look-ahead port giving the entry that follows the head.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_symbol_queue_sym_fifo
  import tx_symbol_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [SYM_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic [SYM_W-1:0] head_o,
  output logic [SYM_W-1:0] next_o,
  output logic             push_acc_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o
);

  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [SYM_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             ovf_q;

  logic             w_push_acc;
  logic             w_pop_acc;
  logic [AW-1:0]    w_rd_nxt;

  assign full_o     = (count_q == C_DEPTH);
  assign empty_o    = (count_q == '0);
  assign w_push_acc = push_i && !full_o;
  assign w_pop_acc  = pop_i && !empty_o;
  assign w_rd_nxt   = rd_ptr_q + C_PTR_ONE;

  assign head_o     = mem_q[rd_ptr_q];
  // With a single stored entry the follower is whatever is being pushed now.
  assign next_o     = (count_q > C_CNT_ONE) ? mem_q[w_rd_nxt] : push_data_i;
  assign push_acc_o = w_push_acc;
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_push_acc) begin
        wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      end
      if (w_pop_acc) begin
        rd_ptr_q <= w_rd_nxt;
      end
      case ({w_push_acc, w_pop_acc})
        2'b10:   count_q <= count_q + C_CNT_ONE;
        2'b01:   count_q <= count_q - C_CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (push_i && full_o) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule : tx_symbol_queue_sym_fifo
`default_nettype wire

// File: rtl/tx_symbol_queue.sv
`default_nettype none
// ============================================================================
// Module      : tx_symbol_queue
// Description : Queues 3-bit symbols and drains them one per link transaction
//               toward the master handshake controller, with a watchdog that
//               aborts a stalled transaction while keeping the symbol queued.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_symbol_queue
  import tx_symbol_queue_pkg::*;
#(
  parameter  int DEPTH          = 8,
  parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [SYM_W-1:0] push_data,
  input  logic             start,
  input  logic             link_valid,
  output logic             req_o,
  output logic [SYM_W-1:0] data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             busy_o,
  output logic             err_o,
  output logic             ovf_o
);

  // Timer is wide enough to hold TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES >= 2).
  localparam int          TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] C_TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] C_TMR_ONE  = TW'(1);
  localparam logic [AW:0]   C_CNT_ONE  = (AW+1)'(1);

  state_e           state_q;
  logic             req_q;
  logic [SYM_W-1:0] data_q;
  logic             err_q;
  logic [TW-1:0]    timer_q;

  logic [SYM_W-1:0] w_head;
  logic [SYM_W-1:0] w_next;
  logic             w_push_acc;
  logic             w_empty;
  logic             w_pop;
  logic             w_start_ok;
  logic             w_more;
  logic             w_timeout;

  // Completion is link_valid seen low after having been seen high.
  assign w_pop      = (state_q == WAIT_LO) && !link_valid;
  // Uses the pre-push occupancy, so a start alongside the first push is ignored.
  assign w_start_ok = (state_q == IDLE) && start && !w_empty;
  // Occupancy after this cycle's pop, counting a push accepted on the same edge.
  assign w_more     = (count_o > C_CNT_ONE) || w_push_acc;
  assign w_timeout  = (timer_q == C_TMR_LAST);

  tx_symbol_queue_sym_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .next_o      (w_next),
    .push_acc_o  (w_push_acc),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (w_empty),
    .ovf_o       (ovf_o)
  );

  // Transaction FSM with watchdog; all outputs registered and updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_start_ok) begin
            state_q <= ISSUE;
            req_q   <= 1'b1;
            data_q  <= w_head;
            err_q   <= 1'b0;
          end
        end
        ISSUE: begin
          state_q <= WAIT_HI;
          timer_q <= '0;
        end
        WAIT_HI: begin
          timer_q <= timer_q + C_TMR_ONE;
          if (w_timeout) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else if (link_valid) begin
            state_q <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          timer_q <= timer_q + C_TMR_ONE;
          // A completion on the timeout edge still counts as a completion.
          if (!link_valid) begin
            if (w_more) begin
              state_q <= ISSUE;
              req_q   <= 1'b1;
              data_q  <= w_next;
            end else begin
              state_q <= IDLE;
            end
          end else if (w_timeout) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_o   = req_q;
  assign data_o  = data_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q != IDLE);
  assign empty_o = w_empty;

endmodule : tx_symbol_queue
`default_nettype wire

// File: tb/tb_tx_symbol_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_symbol_queue
// Description : Directed self-checking bench for tx_symbol_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_symbol_queue;

  localparam int DEPTH = 8;
  localparam int TO    = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic [2:0] push_data = 3'd0;
  logic       start = 1'b0;
  logic       m_lv = 1'b0;
  logic       t_lv = 1'b0;
  logic       link_valid;
  logic       req_o;
  logic [2:0] data_o;
  logic [3:0] count_o;
  logic       full_o, empty_o, busy_o, err_o, ovf_o;

  int  checks = 0;
  int  errors = 0;
  int  req_total = 0;
  bit  master_en = 1'b0;
  int  sent_q[$];
  int  cnt_q[$];

  assign link_valid = m_lv | t_lv;

  always #5 clk = ~clk;

  tx_symbol_queue #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .start      (start),
    .link_valid (link_valid),
    .req_o      (req_o),
    .data_o     (data_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .ovf_o      (ovf_o)
  );

  // Monitor: record every request pulse with its symbol and occupancy.
  always @(negedge clk) begin
    if (req_o) begin
      sent_q.push_back(int'(data_o));
      cnt_q.push_back(int'(count_o));
      req_total++;
    end
  end

  // Model master: link_valid rises 10 cycles after a request, held 5 cycles.
  always begin
    @(negedge clk);
    if (master_en && req_o) begin
      repeat (10) @(negedge clk);
      m_lv = 1'b1;
      repeat (5) @(negedge clk);
      m_lv = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_sym(input logic [2:0] d);
    push = 1'b1;
    push_data = d;
    step();
    push = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sent_q.delete();
    cnt_q.delete();
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_o && n < 300) begin
      step();
      n++;
    end
    chk({nm, "_idle_reached"}, int'(busy_o), 0);
  endtask

  typedef struct {
    logic       p;
    logic [2:0] d;
    int         e_cnt;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Fill table: one idle cycle then nine pushes into an 8-deep queue.
    tbl[0] = '{1'b0, 3'd0, 0, 1'b0, 1'b1, 1'b0};
    for (int i = 1; i <= 8; i++) begin
      tbl[i] = '{1'b1, 3'(i % 8), i, (i == 8), 1'b0, 1'b0};
    end
    tbl[9] = '{1'b1, 3'd3, 8, 1'b1, 1'b0, 1'b1};

    // Reset state.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_count", int'(count_o), 0);
    chk("rst_empty", int'(empty_o), 1);
    chk("rst_full", int'(full_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_req", int'(req_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);

    // A: three symbols drained through the model master.
    master_en = 1'b1;
    do_reset();
    push_sym(3'd5);
    push_sym(3'd2);
    push_sym(3'd7);
    chk("A_count_before", int'(count_o), 3);
    pulse_start();
    chk("A_start_latency_req", int'(req_o), 1);
    wait_idle("A");
    chk("A_num_req", sent_q.size(), 3);
    if (sent_q.size() == 3) begin
      chk("A_data0", sent_q[0], 5);
      chk("A_data1", sent_q[1], 2);
      chk("A_data2", sent_q[2], 7);
      chk("A_cnt0", cnt_q[0], 3);
      chk("A_cnt1", cnt_q[1], 2);
      chk("A_cnt2", cnt_q[2], 1);
    end
    chk("A_count_after", int'(count_o), 0);
    chk("A_empty_after", int'(empty_o), 1);
    repeat (10) step();

    // B: table-driven fill past capacity, then drain the first eight.
    master_en = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push = tbl[i].p;
      push_data = tbl[i].d;
      step();
      push = 1'b0;
      chk($sformatf("B_vec%0d_count", i), int'(count_o), tbl[i].e_cnt);
      chk($sformatf("B_vec%0d_full", i), int'(full_o), int'(tbl[i].e_full));
      chk($sformatf("B_vec%0d_empty", i), int'(empty_o), int'(tbl[i].e_empty));
      chk($sformatf("B_vec%0d_ovf", i), int'(ovf_o), int'(tbl[i].e_ovf));
    end
    master_en = 1'b1;
    pulse_start();
    wait_idle("B");
    chk("B_num_req", sent_q.size(), 8);
    if (sent_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("B_data%0d", i), sent_q[i], (i + 1) % 8);
      end
    end
    chk("B_ovf_sticky", int'(ovf_o), 1);
    repeat (10) step();

    // C: watchdog with link_valid held low, then a successful resend.
    master_en = 1'b0;
    do_reset();
    push_sym(3'd4);
    pulse_start();
    chk("C_req", int'(req_o), 1);
    repeat (TO) step();
    chk("C_busy_before_timeout", int'(busy_o), 1);
    chk("C_err_before_timeout", int'(err_o), 0);
    step();
    chk("C_busy_after_timeout", int'(busy_o), 0);
    chk("C_err_after_timeout", int'(err_o), 1);
    chk("C_count_retained", int'(count_o), 1);
    master_en = 1'b1;
    pulse_start();
    chk("C_resend_req", int'(req_o), 1);
    chk("C_resend_data", int'(data_o), 4);
    chk("C_err_cleared", int'(err_o), 0);
    wait_idle("C");
    chk("C_num_req", sent_q.size(), 2);
    chk("C_count_final", int'(count_o), 0);
    repeat (10) step();

    // D: push and a stray start during WAIT_HI.
    do_reset();
    push_sym(3'd1);
    pulse_start();
    chk("D_req", int'(req_o), 1);
    step();
    step();
    push = 1'b1;
    push_data = 3'd6;
    start = 1'b1;
    step();
    push = 1'b0;
    start = 1'b0;
    chk("D_start_ignored_req", int'(req_o), 0);
    chk("D_count", int'(count_o), 2);
    wait_idle("D");
    chk("D_num_req", sent_q.size(), 2);
    if (sent_q.size() == 2) begin
      chk("D_data0", sent_q[0], 1);
      chk("D_data1", sent_q[1], 6);
    end
    repeat (10) step();

    // E: push on the same edge as a completion pop with two queued.
    master_en = 1'b0;
    do_reset();
    push_sym(3'd3);
    push_sym(3'd5);
    pulse_start();
    chk("E_req_first_data", int'(data_o), 3);
    step();
    t_lv = 1'b1;
    step();
    step();
    t_lv = 1'b0;
    push = 1'b1;
    push_data = 3'd2;
    step();
    push = 1'b0;
    chk("E_count_same", int'(count_o), 2);
    chk("E_next_req", int'(req_o), 1);
    chk("E_next_data", int'(data_o), 5);
    master_en = 1'b1;
    wait_idle("E");
    chk("E_num_req", sent_q.size(), 3);
    if (sent_q.size() == 3) begin
      chk("E_data2", sent_q[2], 2);
    end
    repeat (10) step();

    // F: reset in WAIT_LO with three queued, then start boundary cases.
    master_en = 1'b0;
    do_reset();
    push_sym(3'd1);
    push_sym(3'd2);
    push_sym(3'd3);
    pulse_start();
    step();
    t_lv = 1'b1;
    step();
    step();
    chk("F_busy_wait_lo", int'(busy_o), 1);
    chk("F_count_wait_lo", int'(count_o), 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    t_lv = 1'b0;
    chk("F_rst_count", int'(count_o), 0);
    chk("F_rst_empty", int'(empty_o), 1);
    chk("F_rst_req", int'(req_o), 0);
    chk("F_rst_busy", int'(busy_o), 0);
    chk("F_rst_data", int'(data_o), 0);
    chk("F_rst_err", int'(err_o), 0);
    begin
      int base;
      base = req_total;
      pulse_start();
      repeat (10) step();
      push = 1'b1;
      push_data = 3'd1;
      start = 1'b1;
      step();
      push = 1'b0;
      start = 1'b0;
      repeat (10) step();
      chk("F_no_req_after_reset", req_total - base, 0);
      chk("F_busy_idle", int'(busy_o), 0);
      chk("F_count_one", int'(count_o), 1);
    end
    pulse_start();
    chk("F_new_req", int'(req_o), 1);
    chk("F_new_data", int'(data_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule : tb_tx_symbol_queue
`default_nettype wire
